// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared constants for the serial pattern detector
//
// Purpose : default pattern, match-mode constants and default counter width
//           used by seq_pattern_detector and its testbench.
// Ports   : none (package).
package seq_det_pkg;

   // Classic "1011" detector pattern; MSB is the first bit on the wire.
   localparam logic [3:0] SEQ_DET_PAT_DEFAULT = 4'b1011;

   // Match modes: overlapping keeps history after a hit, non-overlapping clears it.
   localparam bit SEQ_DET_OVERLAP    = 1'b1;
   localparam bit SEQ_DET_NONOVERLAP = 1'b0;

   localparam int SEQ_DET_CNT_W = 8;

endpackage

// File: rtl/seq_det_sat_counter.sv
// rtl/seq_det_sat_counter.sv - width-parametrised saturating counter with clear
//
// Purpose : counts single-cycle increment requests, sticking at all-ones.
//           A clear wins over a simultaneous increment.
// Ports   : i_clk    - clock, rising edge
//           i_reset  - synchronous active-high reset
//           i_clr    - synchronous clear to zero
//           i_inc    - increment request
//           o_count  - current count (registered)
module seq_det_sat_counter #(
   parameter int WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_clr,
   input  logic             i_inc,
   output logic [WIDTH-1:0] o_count
);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_inc && (r_count != {WIDTH{1'b1}})) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/seq_pattern_detector.sv
// rtl/seq_pattern_detector.sv - runtime-loadable serial bit-pattern detector
//
// Purpose : shifts in valid serial bits and pulses `out` for one cycle when the
//           last PAT_W bits equal the loaded pattern. Overlapping or
//           non-overlapping matching selected by OVERLAP.
// Config  : SEQ_DET_COUNT_EN defined -> saturating match counter built;
//           undefined -> match_count tied to 0, cnt_clr ignored.
// Ports   : clk         - clock, rising edge
//           reset       - synchronous active-high reset
//           in          - serial data bit
//           in_valid    - qualifies `in`
//           pat_load    - load pat_in as new pattern (discards a same-cycle bit)
//           pat_in      - new pattern value, MSB received first
//           cnt_clr     - synchronous clear of match_count
//           out         - registered one-cycle match pulse
//           fill        - valid history bits, saturating at PAT_W
//           match_count - saturating match count
module seq_pattern_detector
   import seq_det_pkg::*;
#(
   parameter int               PAT_W    = 4,
   parameter logic [PAT_W-1:0] PAT_INIT = PAT_W'(SEQ_DET_PAT_DEFAULT),
   parameter bit               OVERLAP  = SEQ_DET_OVERLAP,
   parameter int               CNT_W    = SEQ_DET_CNT_W
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in,
   input  logic                       in_valid,
   input  logic                       pat_load,
   input  logic [PAT_W-1:0]           pat_in,
   input  logic                       cnt_clr,
   output logic                       out,
   output logic [$clog2(PAT_W+1)-1:0] fill,
   output logic [CNT_W-1:0]           match_count
);

   localparam int FILL_W       = $clog2(PAT_W+1);
   localparam bit CLEAR_ON_HIT = (OVERLAP == SEQ_DET_NONOVERLAP);

   logic [PAT_W-1:0]  r_shreg;
   logic [FILL_W-1:0] r_fill;
   logic [PAT_W-1:0]  r_pattern;
   logic              r_out;

   logic [PAT_W-1:0]  w_shift;
   logic [FILL_W-1:0] w_fill_inc;
   logic [PAT_W-1:0]  w_shreg_n;
   logic [FILL_W-1:0] w_fill_n;
   logic [PAT_W-1:0]  w_pattern_n;
   logic              w_hit;

   always_comb begin
      w_shift     = {r_shreg[PAT_W-2:0], in};
      w_fill_inc  = (r_fill == FILL_W'(PAT_W)) ? r_fill : r_fill + 1'b1;
      w_shreg_n   = r_shreg;
      w_fill_n    = r_fill;
      w_pattern_n = r_pattern;
      w_hit       = 1'b0;

      if (pat_load) begin
         // New pattern starts from empty history; any bit this cycle is dropped.
         w_pattern_n = pat_in;
         w_fill_n    = '0;
      end else if (in_valid) begin
         w_shreg_n = w_shift;
         w_hit     = (w_fill_inc == FILL_W'(PAT_W)) && (w_shift == r_pattern);
         // Non-overlapping mode only needs fill cleared: PAT_W fresh bits
         // fully overwrite the shift register before the next compare.
         w_fill_n  = (w_hit && CLEAR_ON_HIT) ? '0 : w_fill_inc;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_shreg   <= '0;
         r_fill    <= '0;
         r_pattern <= PAT_INIT;
         r_out     <= 1'b0;
      end else begin
         r_shreg   <= w_shreg_n;
         r_fill    <= w_fill_n;
         r_pattern <= w_pattern_n;
         r_out     <= w_hit;
      end
   end

   assign out  = r_out;
   assign fill = r_fill;

`ifdef SEQ_DET_COUNT_EN
   seq_det_sat_counter #(
      .WIDTH (CNT_W)
   ) u_sat_counter (
      .i_clk   (clk),
      .i_reset (reset),
      .i_clr   (cnt_clr),
      .i_inc   (w_hit),
      .o_count (match_count)
   );
`else
   logic w_unused_cnt_clr;
   assign w_unused_cnt_clr = cnt_clr;
   assign match_count      = '0;
`endif

endmodule

// File: tb/tb_seq_pattern_detector.sv
// tb/tb_seq_pattern_detector.sv - scoreboard bench for seq_pattern_detector
module tb_seq_pattern_detector;
   import seq_det_pkg::*;

`ifdef SEQ_DET_COUNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   localparam int ND = 2;

   logic       clk = 1'b0;
   logic       s_reset = 1'b1;
   logic       s_in = 1'b0;
   logic       s_valid = 1'b0;
   logic       s_load = 1'b0;
   logic [3:0] s_pat = 4'd0;
   logic       s_clr = 1'b0;

   logic       a_out, b_out;
   logic [2:0] a_fill, b_fill;
   logic [7:0] a_cnt;
   logic [1:0] b_cnt;

   always #5 clk = ~clk;

   // A: defaults (overlap, 8-bit counter). B: non-overlap, 2-bit counter.
   seq_pattern_detector u_dut_a (
      .clk         (clk),
      .reset       (s_reset),
      .in          (s_in),
      .in_valid    (s_valid),
      .pat_load    (s_load),
      .pat_in      (s_pat),
      .cnt_clr     (s_clr),
      .out         (a_out),
      .fill        (a_fill),
      .match_count (a_cnt)
   );

   seq_pattern_detector #(
      .OVERLAP (SEQ_DET_NONOVERLAP),
      .CNT_W   (2)
   ) u_dut_b (
      .clk         (clk),
      .reset       (s_reset),
      .in          (s_in),
      .in_valid    (s_valid),
      .pat_load    (s_load),
      .pat_in      (s_pat),
      .cnt_clr     (s_clr),
      .out         (b_out),
      .fill        (b_fill),
      .match_count (b_cnt)
   );

   typedef struct {
      logic o;
      int   f;
      int   c;
   } exp_t;

   int         ovl  [ND] = '{1, 0};
   int         cmax [ND] = '{255, 3};
   bit         hist [ND][$];
   logic [3:0] pat  [ND];
   int         cnt  [ND];
   exp_t       expq [ND][$];

   int compared   = 0;
   int mismatched = 0;

   // Reference: history = bits received since the last clear, last 4 kept.
   task automatic step(input bit r, input bit b, input bit v, input bit l,
                       input logic [3:0] p, input bit c);
      exp_t e;
      bit   hit;
      int   val;
      @(negedge clk);
      s_reset = r; s_in = b; s_valid = v; s_load = l; s_pat = p; s_clr = c;
      for (int d = 0; d < ND; d++) begin
         hit = 1'b0;
         if (r) begin
            hist[d].delete();
            pat[d] = SEQ_DET_PAT_DEFAULT;
            cnt[d] = 0;
         end else begin
            if (l) begin
               pat[d] = p;
               hist[d].delete();
            end else if (v) begin
               hist[d].push_back(b);
               if (hist[d].size() > 4) void'(hist[d].pop_front());
               if (hist[d].size() == 4) begin
                  val = 0;
                  for (int i = 0; i < 4; i++) val = val * 2 + int'(hist[d][i]);
                  hit = (val == int'(pat[d]));
               end
               if (hit && ovl[d] == 0) hist[d].delete();
            end
            if (c) cnt[d] = 0;
            else if (hit && cnt[d] < cmax[d]) cnt[d] = cnt[d] + 1;
         end
         e.o = hit;
         e.f = hist[d].size();
         e.c = CNT_EN ? cnt[d] : 0;
         expq[d].push_back(e);
      end
   endtask

   task automatic bits(input logic [31:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) step(0, v[i], 1, 0, 4'd0, 0);
   endtask

   task automatic check(input int d, input logic o, input int f, input int c);
      exp_t e;
      if (expq[d].size() == 0) return;
      e = expq[d].pop_front();
      compared++;
      if (o !== e.o) begin
         mismatched++;
         $display("FAIL out[%0d] t=%0t got %0b expected %0b", d, $time, o, e.o);
      end
      compared++;
      if (f != e.f) begin
         mismatched++;
         $display("FAIL fill[%0d] t=%0t got %0d expected %0d", d, $time, f, e.f);
      end
      compared++;
      if (c != e.c) begin
         mismatched++;
         $display("FAIL match_count[%0d] t=%0t got %0d expected %0d", d, $time, c, e.c);
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         check(0, a_out, int'(a_fill), int'(a_cnt));
         check(1, b_out, int'(b_fill), int'(b_cnt));
      end
   end

   initial begin
      for (int d = 0; d < ND; d++) begin
         pat[d] = SEQ_DET_PAT_DEFAULT;
         cnt[d] = 0;
      end
      step(1, 0, 0, 0, 4'd0, 0);
      step(1, 1, 1, 1, 4'hF, 1);

      // 1,0,1,1,0,1,1 on default pattern
      bits(32'b1011011, 7);
      step(0, 0, 0, 0, 4'd0, 0);

      // valid gaps between bits 2 and 3
      step(1, 0, 0, 0, 4'd0, 0);
      bits(32'b10, 2);
      repeat (3) step(0, 1, 0, 0, 4'd0, 0);
      bits(32'b11, 2);
      step(0, 0, 0, 0, 4'd0, 0);

      // pat_load with a same-cycle valid bit, then 0110
      bits(32'b10, 2);
      step(0, 1, 1, 1, 4'b0110, 0);
      bits(32'b0110, 4);
      step(0, 0, 0, 0, 4'd0, 0);

      // 1111 with a stream of ones: back-to-back / saturation / clear on hit
      step(0, 0, 0, 1, 4'b1111, 0);
      repeat (23) step(0, 1, 1, 0, 4'd0, 0);
      step(0, 1, 1, 0, 4'd0, 1);
      step(0, 0, 0, 0, 4'd0, 0);

      // reset mid-pattern
      step(1, 0, 0, 0, 4'd0, 0);
      bits(32'b101, 3);
      step(1, 1, 1, 0, 4'd0, 0);
      bits(32'b1, 1);
      step(0, 0, 0, 0, 4'd0, 0);

      // randomized traffic
      for (int k = 0; k < 3000; k++) begin
         step(($urandom % 200) == 0, $urandom % 2, ($urandom % 4) != 0,
              ($urandom % 25) == 0, 4'($urandom % 16), ($urandom % 40) == 0);
      end

      step(0, 0, 0, 0, 4'd0, 0);
      repeat (2) @(negedge clk);
      for (int d = 0; d < ND; d++) begin
         compared++;
         if (expq[d].size() != 0) begin
            mismatched++;
            $display("FAIL drain[%0d] got %0d pending expected 0", d, expq[d].size());
         end
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/seq_pattern_detector.md
# seq_pattern_detector

Parametrised serial bit-pattern detector, the next generation of the fixed 4-bit "1011" Moore/Mealy detectors. It matches a `PAT_W`-bit pattern that can be reloaded at runtime, with overlapping or non-overlapping match mode. It emits a registered one-cycle match pulse and an optional saturating match counter. It sits between a serial bit source (switch/UART deserialiser) and LED/status logic on the Mimas V2 designs.

## Interface
- `PAT_W`, 4, pattern length in bits (2..32)
- `PAT_INIT`, 4'b1011, pattern loaded at reset; MSB is the first bit received
- `OVERLAP`, 1, 1 = overlapping matches allowed, 0 = history cleared after each match
- `CNT_W`, 8, match counter width
- `clk  in  1  system clock; all logic on rising edge`
- `reset  in  1  synchronous, active-high reset`
- `in  in  1  serial data bit`
- `in_valid  in  1  `in` is sampled only when high`
- `pat_load  in  1  load `pat_in` as the new pattern`
- `pat_in  in  PAT_W  new pattern value`
- `cnt_clr  in  1  synchronous clear of `match_count``
- `out  out  1  one-cycle match pulse`
- `fill  out  $clog2(PAT_W+1)  number of valid history bits, saturates at PAT_W`
- `match_count  out  CNT_W  saturating count of matches`

## Operation
- State: `shreg[PAT_W-1:0]` (history), `fill`, `pattern`, `out`, `match_count`.
- On a valid bit: `shreg_n = {shreg[PAT_W-2:0], in}`. `fill_n = min(fill+1, PAT_W)`. `hit = (fill_n == PAT_W) && (shreg_n == pattern)`.
- When `hit`: `out` is 1 next cycle. If `OVERLAP=0`, `fill` is set to 0; `shreg` updates regardless.
- `in_valid=0`: `shreg` and `fill` hold, `out` is 0. No timeout applies.
- `pat_load=1`: `pattern <= pat_in`, `fill <= 0`, `out <= 0`. Takes priority over a simultaneous valid bit, which is discarded.
- Counter: increments on `hit` and saturates at `2^CNT_W-1`, never wrapping. `cnt_clr` has priority, so clear together with hit gives 0.
- Reset: `shreg=0`, `fill=0`, `pattern=PAT_INIT`, `out=0`, `match_count=0`. A reset mid-pattern discards the partial history.

## Timing
- Latency: `out` rises on the clock edge that samples the final pattern bit, so it is visible in the cycle after that bit is presented. It is high for exactly one cycle per match.
- Back-to-back matches (overlap mode, e.g. pattern 1111 with a stream of ones) give `out` high on consecutive cycles.
- `fill`, `match_count` and `out` are all registered. There is no combinational path from inputs to outputs.
- A new pattern is effective for the first valid bit after the `pat_load` cycle.
- `pat_load` with `pat_in` equal to the current pattern still clears `fill`.

## Configuration
- `SEQ_DET_COUNT_EN` defined: the counter and the `cnt_clr` logic are built as specified.
- Undefined: `match_count` is tied to 0 and `cnt_clr` is ignored. The port list is unchanged.

## Structure
- `seq_det_pkg`: default pattern constant `SEQ_DET_PAT_DEFAULT` (4'b1011), mode constants `SEQ_DET_OVERLAP` and `SEQ_DET_NONOVERLAP`, default `CNT_W`.
- Sub-module `seq_det_sat_counter` (width-parametrised saturating counter with clear and inc). It is instantiated only under `SEQ_DET_COUNT_EN`.

## Test plan
- Defaults (PAT 1011, OVERLAP=1), valid stream 1,0,1,1,0,1,1 -> `out` pulses after bits 4 and 7; `match_count=2`.
- OVERLAP=0, same stream -> single pulse after bit 4; `fill` reads 3 at end; `match_count=1`.
- `in_valid` gaps inserted between bits 2 and 3 of "1011" -> match still detected; `fill` holds during gaps.
- `pat_load` with `pat_in=4'b0110` in the same cycle as a valid bit -> bit discarded, `fill=0`; subsequent stream 0,1,1,0 -> one pulse.
- CNT_W=2, 5 matches, then `cnt_clr` in the same cycle as a 6th hit -> count reads 3 (saturated), then 0.
- `reset` asserted after 3 bits of "101" followed by "1" -> no pulse; `fill=1`; all outputs at their reset values during reset.
